regfile_mp: RTL and testbench

Parametrised multi-read-port register file with write-first bypass and a per-register busy scoreboard. It is the next-generation register file for the MIPS pipeline, sitting in the decode stage. Read ports are sampled on the rising edge. The busy scoreboard lets the hazard unit detect RAW dependencies on registers whose producing instruction has issued but not yet written back.

---
 rtl/regfile_mp_if.sv | 28 ++
 rtl/regfile_mp.sv | 81 ++++++++
 tb/tb_regfile_mp.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Decode-stage register file bus: read ports, write-back and issue strobes.
// The master drives addresses and strobes; the slave returns registered data and busy flags.
interface regfile_mp_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [NREAD*AW-1:0]    readAddr;
    logic [NREAD*WIDTH-1:0] readData;
    logic [NREAD-1:0]       readBusy;
    logic                   wrEn;
    logic [AW-1:0]          wrAddr;
    logic [WIDTH-1:0]       wrData;
    logic                   issueEn;
    logic [AW-1:0]          issueAddr;

    modport master (
        output readAddr, wrEn, wrAddr, wrData, issueEn, issueAddr,
        input  readData, readBusy
    );

    modport slave (
        input  readAddr, wrEn, wrAddr, wrData, issueEn, issueAddr,
        output readData, readBusy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-first bypass and a per-register busy scoreboard.
// Read data and busy flags are registered; there is no input-to-output combinational path.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input logic        clk,
    input logic        reset,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH-1:0]       busy;
    logic [DEPTH-1:0]       busyNext;
    logic [AW-1:0]          rdAddr [NREAD];
    logic [NREAD*WIDTH-1:0] readDataNext;
    logic [NREAD*WIDTH-1:0] readDataQ;
    logic [NREAD-1:0]       readBusyNext;
    logic [NREAD-1:0]       readBusyQ;
    logic                   wrOk;
    logic                   issueOk;

    // Out-of-range addresses (non-power-of-two DEPTH) and a hardwired r0 are treated as absent.
    function automatic logic addrValid(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_LIM) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    for (genvar g = 0; g < NREAD; g++) begin : g_rdAddr
        assign rdAddr[g] = bus.readAddr[g*AW +: AW];
    end

    // Issue is applied after write-back so a same-edge new producer keeps the register busy.
    always_comb begin
        wrOk     = bus.wrEn && addrValid(bus.wrAddr);
        issueOk  = bus.issueEn && addrValid(bus.issueAddr);
        busyNext = busy;
        if (wrOk) begin
            busyNext[bus.wrAddr] = 1'b0;
        end
        if (issueOk) begin
            busyNext[bus.issueAddr] = 1'b1;
        end
    end

    always_comb begin
        readDataNext = '0;
        readBusyNext = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (addrValid(rdAddr[p])) begin
                readDataNext[p*WIDTH +: WIDTH] = (wrOk && (bus.wrAddr == rdAddr[p]))
                                               ? bus.wrData : mem[rdAddr[p]];
                readBusyNext[p] = busyNext[rdAddr[p]];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy      <= '0;
            readDataQ <= '0;
            readBusyQ <= '0;
        end else begin
            if (wrOk) begin
                mem[bus.wrAddr] <= bus.wrData;
            end
            busy      <= busyNext;
            readDataQ <= readDataNext;
            readBusyQ <= readBusyNext;
        end
    end

    assign bus.readData = readDataQ;
    assign bus.readBusy = readBusyQ;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations (default, ZERO_REG=0, DEPTH=20/NREAD=4) run
// side by side against an array-based reference model of the register file rules.
module tb_regfile_mp;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int depthOf[ND] = '{32, 32, 20};
    int zeroOf[ND]  = '{1, 0, 1};
    int nrOf[ND]    = '{2, 2, 4};

    logic [4:0]  rA[ND][4];
    logic        wE[ND];
    logic [4:0]  wA[ND];
    logic [31:0] wD[ND];
    logic        iE[ND];
    logic [4:0]  iA[ND];

    logic [31:0] mMem[ND][32];
    bit          mBusy[ND][32];
    logic [31:0] expD[ND][4];
    logic        expB[ND][4];

    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) ifA ();
    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) ifB ();
    regfile_mp_if #(.WIDTH(32), .DEPTH(20), .NREAD(4)) ifC ();

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1)) dutA (.clk(clk), .reset(reset), .bus(ifA));
    regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(0)) dutB (.clk(clk), .reset(reset), .bus(ifB));
    regfile_mp #(.WIDTH(32), .DEPTH(20), .NREAD(4), .ZERO_REG(1)) dutC (.clk(clk), .reset(reset), .bus(ifC));

    function automatic bit legal(int d, int a);
        return (a < depthOf[d]) && !(zeroOf[d] == 1 && a == 0);
    endfunction

    function automatic logic [31:0] actD(int d, int p);
        case (d)
            0:       return ifA.readData[p*32 +: 32];
            1:       return ifB.readData[p*32 +: 32];
            default: return ifC.readData[p*32 +: 32];
        endcase
    endfunction

    function automatic logic actB(int d, int p);
        case (d)
            0:       return ifA.readBusy[p];
            1:       return ifB.readBusy[p];
            default: return ifC.readBusy[p];
        endcase
    endfunction

    task automatic applyInputs();
        ifA.readAddr = {rA[0][1], rA[0][0]};
        ifB.readAddr = {rA[1][1], rA[1][0]};
        ifC.readAddr = {rA[2][3], rA[2][2], rA[2][1], rA[2][0]};
        ifA.wrEn = wE[0]; ifA.wrAddr = wA[0]; ifA.wrData = wD[0]; ifA.issueEn = iE[0]; ifA.issueAddr = iA[0];
        ifB.wrEn = wE[1]; ifB.wrAddr = wA[1]; ifB.wrData = wD[1]; ifB.issueEn = iE[1]; ifB.issueAddr = iA[1];
        ifC.wrEn = wE[2]; ifC.wrAddr = wA[2]; ifC.wrData = wD[2]; ifC.issueEn = iE[2]; ifC.issueAddr = iA[2];
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] r3);
        for (int d = 0; d < ND; d++) begin
            wE[d] = we; wA[d] = wa; wD[d] = wd; iE[d] = ie; iA[d] = ia;
            rA[d][0] = r0; rA[d][1] = r1; rA[d][2] = r2; rA[d][3] = r3;
        end
    endtask

    // One clock: present inputs, predict what each port must show after the edge, advance the model.
    task automatic step();
        bit nb[32];
        applyInputs();
        for (int d = 0; d < ND; d++) begin
            if (reset) begin
                for (int r = 0; r < 32; r++) begin
                    mMem[d][r] = 32'h0;
                    mBusy[d][r] = 1'b0;
                end
                for (int p = 0; p < 4; p++) begin
                    expD[d][p] = 32'h0;
                    expB[d][p] = 1'b0;
                end
            end else begin
                nb = mBusy[d];
                if (wE[d] && legal(d, int'(wA[d]))) nb[wA[d]] = 1'b0;
                if (iE[d] && legal(d, int'(iA[d]))) nb[iA[d]] = 1'b1;
                for (int p = 0; p < 4; p++) begin
                    if (p < nrOf[d] && legal(d, int'(rA[d][p]))) begin
                        expD[d][p] = (wE[d] && wA[d] == rA[d][p]) ? wD[d] : mMem[d][rA[d][p]];
                        expB[d][p] = nb[rA[d][p]];
                    end else begin
                        expD[d][p] = 32'h0;
                        expB[d][p] = 1'b0;
                    end
                end
                if (wE[d] && legal(d, int'(wA[d]))) mMem[d][wA[d]] = wD[d];
                mBusy[d] = nb;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        applyInputs();
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < nrOf[d]; p++) begin
                total++;
                if (actD(d, p) !== 32'h0) begin bad++; $display("FAIL reset_async_data dut%0d p%0d got=%h exp=0", d, p, actD(d, p)); end
                total++;
                if (actB(d, p) !== 1'b0) begin bad++; $display("FAIL reset_async_busy dut%0d p%0d got=%b exp=0", d, p, actB(d, p)); end
            end
        step();
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(a), 5'(a), 5'(a), 5'(a));
            step();
            for (int d = 0; d < ND; d++)
                for (int p = 0; p < nrOf[d]; p++) begin
                    total++;
                    if (actD(d, p) !== 32'h0 || actB(d, p) !== 1'b0) begin
                        bad++; $display("FAIL reset_contents dut%0d r%0d got=%h/%b exp=0/0", d, a, actD(d, p), actB(d, p));
                    end
                end
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 5'd5, 5'd5);
        step();
        total++;
        if (actD(0, 0) !== 32'hDEADBEEF) begin bad++; $display("FAIL write_read_r5 got=%h exp=deadbeef", actD(0, 0)); end
        drive(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd7, 5'd7, 5'd5);
        step();
        total++;
        if (actD(0, 1) !== 32'h12345678) begin bad++; $display("FAIL bypass_r7 got=%h exp=12345678", actD(0, 1)); end
        total++;
        if (actD(0, 0) !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_other_port got=%h exp=deadbeef", actD(0, 0)); end
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < nrOf[d]; p++) begin
                total++;
                if (actD(d, p) !== expD[d][p]) begin bad++; $display("FAIL write_read_model dut%0d p%0d got=%h exp=%h", d, p, actD(d, p), expD[d][p]); end
            end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        step();
        total++;
        if (actD(0, 0) !== 32'h0 || actB(0, 0) !== 1'b0) begin bad++; $display("FAIL zero_reg_on got=%h/%b exp=0/0", actD(0, 0), actB(0, 0)); end
        total++;
        if (actD(1, 0) !== 32'hFFFFFFFF || actB(1, 0) !== 1'b1) begin bad++; $display("FAIL zero_reg_off got=%h/%b exp=ffffffff/1", actD(1, 0), actB(1, 0)); end
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < nrOf[d]; p++) begin
                total++;
                if (actD(d, p) !== expD[d][p] || actB(d, p) !== expB[d][p]) begin
                    bad++; $display("FAIL zero_reg_model dut%0d p%0d got=%h/%b exp=%h/%b", d, p, actD(d, p), actB(d, p), expD[d][p], expB[d][p]);
                end
            end
    endtask

    task automatic test_scoreboard();
        logic [31:0] wantD[4] = '{32'h0, 32'h0, 32'h99, 32'hAA};
        logic        wantB[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: drive(1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9);
                1: drive(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd9, 5'd9, 5'd9);
                2: drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9, 5'd9);
                default: drive(1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9);
            endcase
            step();
            total++;
            if (actD(0, 0) !== wantD[k] || actB(0, 0) !== wantB[k]) begin
                bad++; $display("FAIL scoreboard_r9 step%0d got=%h/%b exp=%h/%b", k, actD(0, 0), actB(0, 0), wantD[k], wantB[k]);
            end
            for (int d = 0; d < ND; d++)
                for (int p = 0; p < nrOf[d]; p++) begin
                    total++;
                    if (actB(d, p) !== expB[d][p]) begin bad++; $display("FAIL scoreboard_model dut%0d p%0d got=%b exp=%b", d, p, actB(d, p), expB[d][p]); end
                end
        end
    endtask

    task automatic test_depth20();
        drive(1'b1, 5'd25, 32'h2525, 1'b1, 5'd25, 5'd25, 5'd19, 5'd25, 5'd19);
        step();
        drive(1'b1, 5'd19, 32'h1919, 1'b1, 5'd19, 5'd25, 5'd19, 5'd25, 5'd19);
        step();
        total++;
        if (actD(2, 1) !== 32'h1919 || actB(2, 1) !== 1'b1) begin bad++; $display("FAIL depth20_r19_bypass got=%h/%b exp=1919/1", actD(2, 1), actB(2, 1)); end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd25, 5'd19, 5'd25, 5'd19);
        step();
        total++;
        if (actD(2, 0) !== 32'h0 || actB(2, 0) !== 1'b0) begin bad++; $display("FAIL depth20_addr25 got=%h/%b exp=0/0", actD(2, 0), actB(2, 0)); end
        total++;
        if (actD(2, 3) !== 32'h1919 || actB(2, 3) !== 1'b1) begin bad++; $display("FAIL depth20_r19 got=%h/%b exp=1919/1", actD(2, 3), actB(2, 3)); end
        total++;
        if (actD(0, 0) !== 32'h2525 || actB(0, 0) !== 1'b1) begin bad++; $display("FAIL depth32_addr25 got=%h/%b exp=2525/1", actD(0, 0), actB(0, 0)); end
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < nrOf[d]; p++) begin
                total++;
                if (actD(d, p) !== expD[d][p] || actB(d, p) !== expB[d][p]) begin
                    bad++; $display("FAIL depth20_model dut%0d p%0d got=%h/%b exp=%h/%b", d, p, actD(d, p), actB(d, p), expD[d][p], expB[d][p]);
                end
            end
    endtask

    task automatic test_nread4();
        logic [31:0] want[4] = '{32'h3333, 32'h3333, 32'h44, 32'h77};
        drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        step();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) drive(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 5'd3, 5'd3, 5'd4, 5'd7);
            else        drive(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd3, 5'd3, 5'd4, 5'd7);
            step();
            for (int p = 0; p < 4; p++) begin
                total++;
                if (actD(2, p) !== want[p]) begin bad++; $display("FAIL nread4 step%0d p%0d got=%h exp=%h", k, p, actD(2, p), want[p]); end
                total++;
                if (actB(2, p) !== expB[2][p]) begin bad++; $display("FAIL nread4_busy step%0d p%0d got=%b exp=%b", k, p, actB(2, p), expB[2][p]); end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < ND; d++) begin
                wE[d] = 1'($urandom_range(1));
                wA[d] = 5'($urandom_range(31));
                wD[d] = 32'($urandom);
                iE[d] = ($urandom_range(2) == 0);
                iA[d] = ($urandom_range(3) == 0) ? wA[d] : 5'($urandom_range(31));
                for (int p = 0; p < 4; p++)
                    rA[d][p] = ($urandom_range(2) == 0) ? wA[d] : 5'($urandom_range(31));
            end
            step();
            for (int d = 0; d < ND; d++)
                for (int p = 0; p < nrOf[d]; p++) begin
                    total++;
                    if (actD(d, p) !== expD[d][p] || actB(d, p) !== expB[d][p]) begin
                        bad++; $display("FAIL random cyc%0d dut%0d p%0d got=%h/%b exp=%h/%b", n, d, p, actD(d, p), actB(d, p), expD[d][p], expB[d][p]);
                    end
                end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 5'd6, 5'd5, 5'd6, 5'd5, 5'd6);
        step();
        total++;
        if (actD(0, 0) !== 32'hA5A5A5A5 || actB(0, 1) !== 1'b1) begin bad++; $display("FAIL reset_mid_pre got=%h/%b exp=a5a5a5a5/1", actD(0, 0), actB(0, 1)); end
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < nrOf[d]; p++) begin
                total++;
                if (actD(d, p) !== 32'h0 || actB(d, p) !== 1'b0) begin bad++; $display("FAIL reset_mid_async dut%0d p%0d got=%h/%b exp=0/0", d, p, actD(d, p), actB(d, p)); end
            end
        drive(1'b1, 5'd8, 32'h8888, 1'b1, 5'd10, 5'd8, 5'd10, 5'd8, 5'd10);
        step();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd8, 5'd10, 5'd5, 5'd6);
            else        drive(1'b1, 5'd11, 32'hB0B0, 1'b1, 5'd12, 5'd11, 5'd12, 5'd11, 5'd12);
            step();
            for (int d = 0; d < ND; d++)
                for (int p = 0; p < nrOf[d]; p++) begin
                    total++;
                    if (actD(d, p) !== expD[d][p] || actB(d, p) !== expB[d][p]) begin
                        bad++; $display("FAIL reset_mid_after step%0d dut%0d p%0d got=%h/%b exp=%h/%b", k, d, p, actD(d, p), actB(d, p), expD[d][p], expB[d][p]);
                    end
                end
        end
        total++;
        if (actD(0, 0) !== 32'hB0B0 || actB(0, 1) !== 1'b1) begin bad++; $display("FAIL reset_mid_first_edge got=%h/%b exp=b0b0/1", actD(0, 0), actB(0, 1)); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_scoreboard();
        test_depth20();
        test_nread4();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
